// File: rtl/joybus_tx.sv
// ============================================================================
// Module      : joybus_tx
// Description : Joybus serial transmitter. Sends up to MAX_BYTES bytes, byte 0
//               first and MSB first, as 4Q bit cells followed by a 1Q/2Q stop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module joybus_tx #(
  parameter int CLKS_PER_US = 50,
  parameter int MAX_BYTES   = 8,
  localparam int LEN_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tx_start,
  input  logic [LEN_W-1:0]       tx_len,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  input  logic                   stop_long,
  output logic                   JB_TX,
  output logic                   tx_busy,
  output logic                   tx_done
);

  // Bit counter spans 0 .. 8*MAX_BYTES; clog2(8*N+1) equals clog2(N+1)+3.
  localparam int BIT_W = LEN_W + 3;
  localparam int PH_W  = $clog2(3 * CLKS_PER_US + 1);

  localparam logic [PH_W-1:0]  c_q1_end  = PH_W'(CLKS_PER_US - 1);
  localparam logic [PH_W-1:0]  c_q2_end  = PH_W'(2 * CLKS_PER_US - 1);
  localparam logic [PH_W-1:0]  c_q3_end  = PH_W'(3 * CLKS_PER_US - 1);
  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_BYTES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BIT_LOW  = 2'd1,
    BIT_HIGH = 2'd2,
    STOP_LOW = 2'd3
  } state_t;

  state_t                 r_state;
  logic [PH_W-1:0]        r_ph;
  logic [BIT_W-1:0]       r_bit;
  logic [BIT_W-1:0]       r_last;
  logic [8*MAX_BYTES-1:0] r_data;
  logic                   r_stop_long;
  logic                   r_jb_tx;
  logic                   r_busy;
  logic                   r_done;

  state_t                 w_state_n;
  logic [PH_W-1:0]        w_ph_n;
  logic [BIT_W-1:0]       w_bit_n;
  logic [BIT_W-1:0]       w_last_n;
  logic [8*MAX_BYTES-1:0] w_data_n;
  logic                   w_stop_long_n;
  logic                   w_done_n;

  logic [LEN_W-1:0]       w_eff_len;
  logic [7:0]             w_byte;
  logic                   w_bit;
  logic [PH_W-1:0]        w_low_end;
  logic [PH_W-1:0]        w_high_end;
  logic [PH_W-1:0]        w_stop_end;

  assign w_eff_len  = (tx_len > c_max_len) ? c_max_len : tx_len;
  // The current byte always sits in the low 8 bits; MSB goes out first.
  assign w_byte     = r_data[7:0];
  assign w_bit      = w_byte[~r_bit[2:0]];
  assign w_low_end  = w_bit ? c_q1_end : c_q3_end;
  assign w_high_end = w_bit ? c_q3_end : c_q1_end;
  assign w_stop_end = r_stop_long ? c_q2_end : c_q1_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ph        <= '0;
      r_bit       <= '0;
      r_last      <= '0;
      r_data      <= '0;
      r_stop_long <= 1'b0;
      r_jb_tx     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_ph        <= w_ph_n;
      r_bit       <= w_bit_n;
      r_last      <= w_last_n;
      r_data      <= w_data_n;
      r_stop_long <= w_stop_long_n;
      r_jb_tx     <= (w_state_n == IDLE) || (w_state_n == BIT_HIGH);
      r_busy      <= (w_state_n != IDLE);
      r_done      <= w_done_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_ph_n        = r_ph + PH_W'(1);
    w_bit_n       = r_bit;
    w_last_n      = r_last;
    w_data_n      = r_data;
    w_stop_long_n = r_stop_long;
    w_done_n      = 1'b0;

    case (r_state)
      IDLE: begin
        w_ph_n  = '0;
        w_bit_n = '0;
        if (tx_start) begin
          w_data_n      = tx_data;
          w_stop_long_n = stop_long;
          if (w_eff_len == '0) begin
            w_done_n = 1'b1;
          end else begin
            w_state_n = BIT_LOW;
            w_last_n  = {w_eff_len, 3'b000} - BIT_W'(1);
          end
        end
      end

      BIT_LOW: begin
        if (r_ph == w_low_end) begin
          w_state_n = BIT_HIGH;
          w_ph_n    = '0;
        end
      end

      BIT_HIGH: begin
        if (r_ph == w_high_end) begin
          w_ph_n = '0;
          if (r_bit == r_last) begin
            w_state_n = STOP_LOW;
          end else begin
            w_state_n = BIT_LOW;
            w_bit_n   = r_bit + BIT_W'(1);
            if (r_bit[2:0] == 3'b111) begin
              w_data_n = r_data >> 8;
            end
          end
        end
      end

      STOP_LOW: begin
        if (r_ph == w_stop_end) begin
          w_state_n = IDLE;
          w_ph_n    = '0;
          w_done_n  = 1'b1;
        end
      end

      default: begin
        w_state_n = IDLE;
        w_ph_n    = '0;
      end
    endcase
  end

  assign JB_TX   = r_jb_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

`default_nettype wire
